// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: one clock domain with a pixel clock-enable,
// registered sync/blank/coordinates that are always mutually coherent.
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int CLK_DIV   = 2,
  parameter bit HS_POL    = 1'b0,
  parameter bit VS_POL    = 1'b0,
  parameter int XW        = 10,
  parameter int YW        = 10
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          restart,
  output logic          pixel_ce,
  output logic          hs,
  output logic          vs,
  output logic          blank,
  output logic          sync,
  output logic [XW-1:0] DrawX,
  output logic [YW-1:0] DrawY,
  output logic          line_start,
  output logic          frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [XW-1:0] H_LAST   = XW'(H_TOTAL - 1);
  localparam logic [YW-1:0] V_LAST   = YW'(V_TOTAL - 1);

  // One extra bit so a window ending exactly at 2^XW (or 2^YW) still compares correctly.
  localparam logic [XW:0] H_VIS_X  = (XW+1)'(H_VISIBLE);
  localparam logic [XW:0] HS_BEG_X = (XW+1)'(H_VISIBLE + H_FRONT);
  localparam logic [XW:0] HS_END_X = (XW+1)'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [YW:0] V_VIS_X  = (YW+1)'(V_VISIBLE);
  localparam logic [YW:0] VS_BEG_X = (YW+1)'(V_VISIBLE + V_FRONT);
  localparam logic [YW:0] VS_END_X = (YW+1)'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [DW-1:0] div_cnt;
  logic [DW-1:0] div_nxt;
  logic [XW-1:0] hc_nxt;
  logic [YW-1:0] vc_nxt;
  logic          hs_act;
  logic          vs_act;
  logic          blank_nxt;
  logic          line_start_nxt;
  logic          frame_start_nxt;

  assign pixel_ce = (div_cnt == DIV_LAST);

  // Next counter position; restart reloads the end-of-frame position, same as reset.
  always_comb begin
    div_nxt = pixel_ce ? '0 : div_cnt + DW'(1);
    hc_nxt  = DrawX;
    vc_nxt  = DrawY;
    if (restart) begin
      div_nxt = '0;
      hc_nxt  = H_LAST;
      vc_nxt  = V_LAST;
    end else if (pixel_ce) begin
      if (DrawX == H_LAST) begin
        hc_nxt = '0;
        vc_nxt = (DrawY == V_LAST) ? '0 : DrawY + YW'(1);
      end else begin
        hc_nxt = DrawX + XW'(1);
      end
    end

    hs_act          = ({1'b0, hc_nxt} >= HS_BEG_X) && ({1'b0, hc_nxt} < HS_END_X);
    vs_act          = ({1'b0, vc_nxt} >= VS_BEG_X) && ({1'b0, vc_nxt} < VS_END_X);
    blank_nxt       = ({1'b0, hc_nxt} < H_VIS_X) && ({1'b0, vc_nxt} < V_VIS_X);
    line_start_nxt  = !restart && pixel_ce && (hc_nxt == '0);
    frame_start_nxt = line_start_nxt && (vc_nxt == '0);
  end

  // Counters and decoded outputs load on the same edge.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      div_cnt     <= '0;
      DrawX       <= H_LAST;
      DrawY       <= V_LAST;
      hs          <= ~HS_POL;
      vs          <= ~VS_POL;
      blank       <= 1'b0;
      sync        <= 1'b1;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      div_cnt     <= div_nxt;
      DrawX       <= hc_nxt;
      DrawY       <= vc_nxt;
      hs          <= hs_act ? HS_POL : ~HS_POL;
      vs          <= vs_act ? VS_POL : ~VS_POL;
      blank       <= blank_nxt;
      sync        <= ~(hs_act | vs_act);
      line_start  <= line_start_nxt;
      frame_start <= frame_start_nxt;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default 640x480 mode plus a tiny mode in both sync polarities.
module tb_vga_timing_gen;

  logic Clk;
  logic Reset_n;
  logic restart_a;
  logic restart_bc;

  logic       a_pce, a_hs, a_vs, a_blank, a_sync, a_ls, a_fs;
  logic [9:0] a_x, a_y;
  logic       b_pce, b_hs, b_vs, b_blank, b_sync, b_ls, b_fs;
  logic [3:0] b_x, b_y;
  logic       c_pce, c_hs, c_vs, c_blank, c_sync, c_ls, c_fs;
  logic [3:0] c_x, c_y;

  int n_checks;
  int n_fail;

  vga_timing_gen dut_a (
    .Clk(Clk), .Reset_n(Reset_n), .restart(restart_a),
    .pixel_ce(a_pce), .hs(a_hs), .vs(a_vs), .blank(a_blank), .sync(a_sync),
    .DrawX(a_x), .DrawY(a_y), .line_start(a_ls), .frame_start(a_fs)
  );

  vga_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .CLK_DIV(1), .HS_POL(1'b0), .VS_POL(1'b0), .XW(4), .YW(4)
  ) dut_b (
    .Clk(Clk), .Reset_n(Reset_n), .restart(restart_bc),
    .pixel_ce(b_pce), .hs(b_hs), .vs(b_vs), .blank(b_blank), .sync(b_sync),
    .DrawX(b_x), .DrawY(b_y), .line_start(b_ls), .frame_start(b_fs)
  );

  vga_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .CLK_DIV(1), .HS_POL(1'b1), .VS_POL(1'b1), .XW(4), .YW(4)
  ) dut_c (
    .Clk(Clk), .Reset_n(Reset_n), .restart(restart_bc),
    .pixel_ce(c_pce), .hs(c_hs), .vs(c_vs), .blank(c_blank), .sync(c_sync),
    .DrawX(c_x), .DrawY(c_y), .line_start(c_ls), .frame_start(c_fs)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic test_reset();
    Reset_n = 1'b0;
    restart_a = 1'b0;
    restart_bc = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    n_checks++;
    if ({a_x, a_y} !== {10'd799, 10'd524}) begin
      n_fail++;
      $display("FAIL reset_pos: got (%0d,%0d) required (799,524)", a_x, a_y);
    end
    n_checks++;
    if ({a_blank, a_hs, a_vs, a_sync, a_ls, a_fs, a_pce} !== 7'b0111000) begin
      n_fail++;
      $display("FAIL reset_flags: got %b required 0111000 (blank,hs,vs,sync,ls,fs,pce)",
               {a_blank, a_hs, a_vs, a_sync, a_ls, a_fs, a_pce});
    end
    // release in cycle 0
    Reset_n = 1'b1;
    n_checks++;
    if (a_pce !== 1'b0) begin
      n_fail++;
      $display("FAIL cycle0_pce: got %b required 0", a_pce);
    end
    @(posedge Clk); #1;
    n_checks++;
    if ({a_pce, a_fs, a_ls, a_x} !== {1'b1, 1'b0, 1'b0, 10'd799}) begin
      n_fail++;
      $display("FAIL cycle1: got pce=%b fs=%b ls=%b x=%0d required pce=1 fs=0 ls=0 x=799",
               a_pce, a_fs, a_ls, a_x);
    end
    @(posedge Clk); #1;
    n_checks++;
    if ({a_x, a_y} !== 20'd0) begin
      n_fail++;
      $display("FAIL cycle2_pos: got (%0d,%0d) required (0,0)", a_x, a_y);
    end
    n_checks++;
    if ({a_blank, a_fs, a_ls, a_hs, a_vs, a_sync} !== 6'b111111) begin
      n_fail++;
      $display("FAIL cycle2_flags: got %b required 111111 (blank,fs,ls,hs,vs,sync)",
               {a_blank, a_fs, a_ls, a_hs, a_vs, a_sync});
    end
    @(posedge Clk); #1;
    n_checks++;
    if ({a_fs, a_ls, a_x} !== {1'b0, 1'b0, 10'd0}) begin
      n_fail++;
      $display("FAIL cycle3: got fs=%b ls=%b x=%0d required fs=0 ls=0 x=0", a_fs, a_ls, a_x);
    end
  endtask

  // Offset k counts Clk edges since (0,0) loaded; k=1 was sampled by test_reset.
  task automatic test_line();
    int e_pos, e_hs, e_vs, e_blank, e_sync, e_ls, e_fs, e_pce;
    int hs_low, ls_cnt, ls_prev, ls_period;
    logic [9:0] ex, ey;
    logic hs_act;
    e_pos = 0; e_hs = 0; e_vs = 0; e_blank = 0; e_sync = 0; e_ls = 0; e_fs = 0; e_pce = 0;
    hs_low = 0; ls_cnt = 0; ls_prev = 0; ls_period = 0;
    for (int k = 2; k <= 3200; k++) begin
      @(posedge Clk); #1;
      ex = 10'((k / 2) % 800);
      ey = 10'(k / 1600);
      hs_act = (ex >= 10'd656) && (ex < 10'd752);
      if ({a_x, a_y} !== {ex, ey}) e_pos++;
      if (a_hs !== !hs_act) e_hs++;
      if (a_vs !== 1'b1) e_vs++;
      if (a_blank !== ((ex < 10'd640) && (ey < 10'd480))) e_blank++;
      if (a_sync !== !hs_act) e_sync++;
      if (a_ls !== (k % 1600 == 0)) e_ls++;
      if (a_fs !== 1'b0) e_fs++;
      if (a_pce !== (k % 2 == 1)) e_pce++;
      if (k < 1600 && a_hs === 1'b0) hs_low++;
      if (a_ls === 1'b1) begin
        if (ls_cnt > 0) ls_period = k - ls_prev;
        ls_prev = k;
        ls_cnt++;
      end
    end
    n_checks++;
    if (e_pos != 0) begin n_fail++; $display("FAIL line_pos: %0d bad cycles, required 0", e_pos); end
    n_checks++;
    if (e_hs != 0) begin n_fail++; $display("FAIL line_hs: %0d bad cycles, required 0", e_hs); end
    n_checks++;
    if (e_vs != 0) begin n_fail++; $display("FAIL line_vs: %0d bad cycles, required 0", e_vs); end
    n_checks++;
    if (e_blank != 0) begin n_fail++; $display("FAIL line_blank: %0d bad cycles, required 0", e_blank); end
    n_checks++;
    if (e_sync != 0) begin n_fail++; $display("FAIL line_sync: %0d bad cycles, required 0", e_sync); end
    n_checks++;
    if (e_ls != 0) begin n_fail++; $display("FAIL line_ls: %0d bad cycles, required 0", e_ls); end
    n_checks++;
    if (e_fs != 0) begin n_fail++; $display("FAIL line_fs: %0d bad cycles, required 0", e_fs); end
    n_checks++;
    if (e_pce != 0) begin n_fail++; $display("FAIL line_pce: %0d bad cycles, required 0", e_pce); end
    n_checks++;
    if (hs_low != 192) begin n_fail++; $display("FAIL line_hs_width: got %0d Clk required 192", hs_low); end
    n_checks++;
    if (ls_cnt != 2 || ls_period != 1600) begin
      n_fail++;
      $display("FAIL line_period: got %0d strobes period %0d required 2 period 1600", ls_cnt, ls_period);
    end
  endtask

  task automatic test_restart();
    int e_hold;
    repeat (600) @(posedge Clk);
    #1;
    n_checks++;
    if ({a_x, a_y, a_pce} !== {10'd300, 10'd2, 1'b0}) begin
      n_fail++;
      $display("FAIL restart_setup: got (%0d,%0d) pce=%b required (300,2) pce=0", a_x, a_y, a_pce);
    end
    restart_a = 1'b1;
    @(posedge Clk); #1;
    restart_a = 1'b0;
    n_checks++;
    if ({a_x, a_y} !== {10'd799, 10'd524}) begin
      n_fail++;
      $display("FAIL restart_pos: got (%0d,%0d) required (799,524)", a_x, a_y);
    end
    n_checks++;
    if ({a_blank, a_ls, a_fs, a_pce, a_hs, a_vs, a_sync} !== 7'b0000111) begin
      n_fail++;
      $display("FAIL restart_flags: got %b required 0000111 (blank,ls,fs,pce,hs,vs,sync)",
               {a_blank, a_ls, a_fs, a_pce, a_hs, a_vs, a_sync});
    end
    @(posedge Clk); #1;
    n_checks++;
    if ({a_pce, a_fs, a_ls, a_x} !== {1'b1, 1'b0, 1'b0, 10'd799}) begin
      n_fail++;
      $display("FAIL restart_plus1: got pce=%b fs=%b ls=%b x=%0d required 1 0 0 799", a_pce, a_fs, a_ls, a_x);
    end
    @(posedge Clk); #1;
    n_checks++;
    if ({a_fs, a_ls, a_x, a_y} !== {1'b1, 1'b1, 10'd0, 10'd0}) begin
      n_fail++;
      $display("FAIL restart_plus2: got fs=%b ls=%b (%0d,%0d) required 1 1 (0,0)", a_fs, a_ls, a_x, a_y);
    end
    // Held restart, first asserted on a pixel_ce cycle: counters must not advance.
    @(posedge Clk); #1;
    n_checks++;
    if (a_pce !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_setup_pce: got %b required 1", a_pce);
    end
    restart_a = 1'b1;
    e_hold = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge Clk); #1;
      if ({a_x, a_y, a_pce, a_fs, a_ls} !== {10'd799, 10'd524, 3'b000}) e_hold++;
    end
    restart_a = 1'b0;
    n_checks++;
    if (e_hold != 0) begin n_fail++; $display("FAIL restart_hold: %0d bad cycles, required 0", e_hold); end
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    n_checks++;
    if ({a_fs, a_x, a_y} !== {1'b1, 20'd0}) begin
      n_fail++;
      $display("FAIL hold_release: got fs=%b (%0d,%0d) required 1 (0,0)", a_fs, a_x, a_y);
    end
  endtask

  // Tiny mode: H_TOTAL=12, hs window 9..10; V_TOTAL=7, vs window 5; CLK_DIV=1.
  task automatic test_small_mode();
    int e_b, e_c, e_pce, fs_cnt, fs_prev, fs_period;
    logic [3:0] ex, ey;
    logic hs_act, vs_act, ebl;
    Reset_n = 1'b0;
    #1;
    n_checks++;
    if ({b_x, b_y, b_blank, b_hs, b_vs, b_sync, b_ls, b_fs, b_pce} !== {4'd11, 4'd6, 7'b0111001}) begin
      n_fail++;
      $display("FAIL small_reset_b: got (%0d,%0d) flags %b required (11,6) 0111001",
               b_x, b_y, {b_blank, b_hs, b_vs, b_sync, b_ls, b_fs, b_pce});
    end
    n_checks++;
    if ({c_blank, c_hs, c_vs, c_sync, c_pce} !== 5'b00011) begin
      n_fail++;
      $display("FAIL small_reset_c: got %b required 00011 (blank,hs,vs,sync,pce)",
               {c_blank, c_hs, c_vs, c_sync, c_pce});
    end
    @(posedge Clk); #1;
    Reset_n = 1'b1;
    e_b = 0; e_c = 0; e_pce = 0; fs_cnt = 0; fs_prev = 0; fs_period = 0;
    for (int k = 0; k <= 168; k++) begin
      @(posedge Clk); #1;
      ex = 4'(k % 12);
      ey = 4'((k / 12) % 7);
      hs_act = (ex == 4'd9) || (ex == 4'd10);
      vs_act = (ey == 4'd5);
      ebl = (ex < 4'd8) && (ey < 4'd4);
      if ({b_x, b_y, b_hs, b_vs, b_blank, b_sync, b_ls, b_fs} !==
          {ex, ey, !hs_act, !vs_act, ebl, !(hs_act || vs_act), ex == 4'd0, (ex == 4'd0) && (ey == 4'd0)})
        e_b++;
      if ({c_x, c_y, c_hs, c_vs, c_blank, c_sync, c_ls, c_fs} !==
          {ex, ey, hs_act, vs_act, ebl, !(hs_act || vs_act), ex == 4'd0, (ex == 4'd0) && (ey == 4'd0)})
        e_c++;
      if (b_pce !== 1'b1 || c_pce !== 1'b1) e_pce++;
      if (b_fs === 1'b1) begin
        if (fs_cnt > 0) fs_period = k - fs_prev;
        fs_prev = k;
        fs_cnt++;
      end
    end
    n_checks++;
    if (e_b != 0) begin n_fail++; $display("FAIL small_pol0: %0d bad cycles, required 0", e_b); end
    n_checks++;
    if (e_c != 0) begin n_fail++; $display("FAIL small_pol1: %0d bad cycles, required 0", e_c); end
    n_checks++;
    if (e_pce != 0) begin n_fail++; $display("FAIL small_pce: %0d bad cycles, required 0", e_pce); end
    n_checks++;
    if (fs_cnt != 3 || fs_period != 84) begin
      n_fail++;
      $display("FAIL small_frame_period: got %0d strobes period %0d required 3 period 84", fs_cnt, fs_period);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    Reset_n = 1'b0;
    restart_a = 1'b0;
    restart_bc = 1'b0;
    test_reset();
    test_line();
    test_restart();
    test_small_mode();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
